// File: rtl/gpu_mem_pkg.sv
// Shared definitions for the frame-SRAM access path: default bus widths,
// arbiter state encoding and client-index width helper.
package gpu_mem_pkg;

  localparam int DEFAULT_ADDR_W = 24;
  localparam int DEFAULT_DATA_W = 1536;
  localparam int MAX_CLIENTS    = 8;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } arb_state_e;

  // Width of an index able to address n items; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sram_port_arbiter_rr_pick.sv
// Combinational round-robin selector: first asserted request at or after
// the pointer, wrapping, reported as one-hot, index and any-flag.
module rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_pick,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  localparam logic [N-1:0] ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0] w_rot;
  int           w_off;

  // Bit k of the rotated vector is client (ptr + k) mod N.
  assign w_rot = N'({i_req, i_req} >> i_ptr);

  // Lowest set bit of the rotated vector wins; map it back to a client.
  always_comb begin
    w_off = 0;
    for (int k = N - 1; k >= 0; k--) begin
      w_off = w_rot[k] ? k : w_off;
    end
    o_any = |w_rot;
    o_idx = IDX_W'((int'(i_ptr) + w_off) % N);
    if (o_any) begin
      o_pick = ONE_HOT0 << o_idx;
    end else begin
      o_pick = '0;
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// N-client round-robin owner arbiter for the shared frame-SRAM port with
// lock, hold-time preemption and read-valid routing across SRAM latency.
module sram_port_arbiter
  import gpu_mem_pkg::*;
#(
  parameter int NUM_CLIENTS = 2,
  parameter int ADDR_W      = DEFAULT_ADDR_W,
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int RD_LATENCY  = 1,
  parameter int MAX_HOLD    = 0
) (
  input  logic                          i_clk,
  input  logic                          i_n_rst,
  input  logic [NUM_CLIENTS-1:0]        i_req,
  input  logic [NUM_CLIENTS-1:0]        i_lock,
  input  logic [NUM_CLIENTS-1:0]        i_c_read_enable,
  input  logic [NUM_CLIENTS-1:0]        i_c_write_enable,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] i_c_address,
  input  logic [NUM_CLIENTS*DATA_W-1:0] i_c_write_data,
  input  logic [DATA_W-1:0]             i_read_data,
  output logic [NUM_CLIENTS-1:0]        o_gnt,
  output logic [NUM_CLIENTS-1:0]        o_rdata_valid,
  output logic [DATA_W-1:0]             o_c_read_data,
  output logic                          o_read_enable,
  output logic                          o_write_enable,
  output logic [ADDR_W-1:0]             o_address,
  output logic [DATA_W-1:0]             o_write_data,
  output logic                          o_protocol_err
);

  localparam int IDX_W  = idx_width(NUM_CLIENTS);
  localparam int HOLD_W = idx_width(MAX_HOLD + 1);
  localparam logic [NUM_CLIENTS-1:0] ONE_HOT0 = {{(NUM_CLIENTS-1){1'b0}}, 1'b1};

  typedef logic [IDX_W-1:0] client_idx_t;

  arb_state_e             r_state, w_state_nxt;
  logic [NUM_CLIENTS-1:0] r_gnt, w_gnt_nxt;
  client_idx_t            r_owner, w_owner_nxt;
  client_idx_t            r_rr, w_rr_nxt;
  logic [HOLD_W-1:0]      r_hold, w_hold_nxt;

  logic [NUM_CLIENTS-1:0] w_pick_req, w_pick_oh;
  client_idx_t            w_pick_ptr, w_pick_idx, w_ptr_after;
  logic                   w_pick_any;
  logic                   w_owner_req, w_owner_lock, w_others;
  logic                   w_hold_full, w_preempt, w_handover;

  logic                   w_acc_ok, w_sel_re, w_sel_we;
  logic [ADDR_W-1:0]      w_sel_addr;
  logic [DATA_W-1:0]      w_sel_wdata;

  logic                   r_re, r_we, r_err;
  logic [ADDR_W-1:0]      r_addr;
  logic [DATA_W-1:0]      r_wdata;
  client_idx_t            r_rd_idx;
  logic [RD_LATENCY-1:0]  r_tag_vld;
  client_idx_t            r_tag_idx [RD_LATENCY];

  assign w_owner_req  = |(i_req & r_gnt);
  assign w_owner_lock = |(i_lock & r_gnt);
  assign w_others     = |(i_req & ~r_gnt);
  assign w_hold_full  = (r_hold == HOLD_W'(MAX_HOLD));
  assign w_preempt    = (MAX_HOLD > 0) && w_hold_full && w_others && !w_owner_lock;
  assign w_handover   = (r_state == ST_OWNED) && (!w_owner_req || w_preempt);
  assign w_ptr_after  = (r_owner == client_idx_t'(NUM_CLIENTS - 1)) ? '0 : r_owner + client_idx_t'(1);

  // On handover the current owner is masked so a preempted owner cannot re-win.
  always_comb begin
    if (r_state == ST_OWNED) begin
      w_pick_req = i_req & ~r_gnt;
      w_pick_ptr = w_ptr_after;
    end else begin
      w_pick_req = i_req;
      w_pick_ptr = r_rr;
    end
  end

  rr_pick #(
    .N     (NUM_CLIENTS),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .i_req  (w_pick_req),
    .i_ptr  (w_pick_ptr),
    .o_pick (w_pick_oh),
    .o_idx  (w_pick_idx),
    .o_any  (w_pick_any)
  );

  // Ownership next-state: grant from idle, handover on release/preempt, hold count.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_owner_nxt = r_owner;
    w_rr_nxt    = r_rr;
    w_hold_nxt  = r_hold;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_any) begin
          w_state_nxt = ST_OWNED;
          w_gnt_nxt   = w_pick_oh;
          w_owner_nxt = w_pick_idx;
          w_hold_nxt  = '0;
        end else begin
          w_gnt_nxt = '0;
        end
      end
      ST_OWNED: begin
        if (w_handover) begin
          w_rr_nxt   = w_ptr_after;
          w_hold_nxt = '0;
          if (w_pick_any) begin
            w_gnt_nxt   = w_pick_oh;
            w_owner_nxt = w_pick_idx;
          end else begin
            w_state_nxt = ST_IDLE;
            w_gnt_nxt   = '0;
          end
        end else if (!w_hold_full) begin
          w_hold_nxt = r_hold + HOLD_W'(1);
        end else begin
          w_hold_nxt = r_hold;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  // Ownership state register.
  always_ff @(posedge i_clk) begin
    if (!i_n_rst) begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_owner <= '0;
      r_rr    <= '0;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_owner <= w_owner_nxt;
      r_rr    <= w_rr_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  // An owner that has dropped req gets no further access, even this cycle.
  assign w_acc_ok    = (r_state == ST_OWNED) && w_owner_req;
  assign w_sel_re    = |(i_c_read_enable & r_gnt);
  assign w_sel_we    = |(i_c_write_enable & r_gnt);
  assign w_sel_addr  = i_c_address[int'(r_owner) * ADDR_W +: ADDR_W];
  assign w_sel_wdata = i_c_write_data[int'(r_owner) * DATA_W +: DATA_W];

  // SRAM-side command stage; write wins over a simultaneous read.
  always_ff @(posedge i_clk) begin
    if (!i_n_rst) begin
      r_re     <= 1'b0;
      r_we     <= 1'b0;
      r_err    <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rd_idx <= '0;
    end else begin
      r_re     <= w_acc_ok && w_sel_re && !w_sel_we;
      r_we     <= w_acc_ok && w_sel_we;
      r_rd_idx <= r_owner;
      if (w_acc_ok && (w_sel_re || w_sel_we)) begin
        r_addr <= w_sel_addr;
      end
      if (w_acc_ok && w_sel_we) begin
        r_wdata <= w_sel_wdata;
      end
      if (w_acc_ok && w_sel_re && w_sel_we) begin
        r_err <= 1'b1;
      end
    end
  end

  // Read tags ride alongside the SRAM latency, independent of current ownership.
  always_ff @(posedge i_clk) begin
    if (!i_n_rst) begin
      r_tag_vld <= '0;
      for (int s = 0; s < RD_LATENCY; s++) begin
        r_tag_idx[s] <= '0;
      end
    end else begin
      r_tag_vld[0] <= r_re;
      r_tag_idx[0] <= r_rd_idx;
      for (int s = 1; s < RD_LATENCY; s++) begin
        r_tag_vld[s] <= r_tag_vld[s-1];
        r_tag_idx[s] <= r_tag_idx[s-1];
      end
    end
  end

  // Decode the pipeline tail into the per-client read-valid strobe.
  always_comb begin
    if (r_tag_vld[RD_LATENCY-1]) begin
      o_rdata_valid = ONE_HOT0 << r_tag_idx[RD_LATENCY-1];
    end else begin
      o_rdata_valid = '0;
    end
  end

  assign o_gnt          = r_gnt;
  assign o_c_read_data  = i_read_data;
  assign o_read_enable  = r_re;
  assign o_write_enable = r_we;
  assign o_address      = r_addr;
  assign o_write_data   = r_wdata;
  assign o_protocol_err = r_err;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench: a 2-client/latency-1 instance and a 4-client/latency-3/
// hold-4 instance driven with hand-computed expectations.
module tb_sram_port_arbiter;

  logic        clk;
  logic        a_rst_n, b_rst_n;
  logic [31:0] rdata_in;

  logic [1:0]  a_req, a_lock, a_re, a_we;
  logic [47:0] a_addr;
  logic [63:0] a_wdata;
  logic [1:0]  a_gnt, a_rdv;
  logic [31:0] a_crd, a_wd_out;
  logic        a_ren, a_wen, a_err;
  logic [23:0] a_address;

  logic [3:0]   b_req, b_lock, b_re, b_we;
  logic [95:0]  b_addr;
  logic [127:0] b_wdata;
  logic [3:0]   b_gnt, b_rdv;
  logic [31:0]  b_crd, b_wd_out;
  logic         b_ren, b_wen, b_err;
  logic [23:0]  b_address;

  int n_cmp = 0;
  int n_bad = 0;

  sram_port_arbiter #(
    .NUM_CLIENTS(2), .ADDR_W(24), .DATA_W(32), .RD_LATENCY(1), .MAX_HOLD(0)
  ) dut_a (
    .i_clk(clk), .i_n_rst(a_rst_n), .i_req(a_req), .i_lock(a_lock),
    .i_c_read_enable(a_re), .i_c_write_enable(a_we), .i_c_address(a_addr),
    .i_c_write_data(a_wdata), .i_read_data(rdata_in), .o_gnt(a_gnt),
    .o_rdata_valid(a_rdv), .o_c_read_data(a_crd), .o_read_enable(a_ren),
    .o_write_enable(a_wen), .o_address(a_address), .o_write_data(a_wd_out),
    .o_protocol_err(a_err)
  );

  sram_port_arbiter #(
    .NUM_CLIENTS(4), .ADDR_W(24), .DATA_W(32), .RD_LATENCY(3), .MAX_HOLD(4)
  ) dut_b (
    .i_clk(clk), .i_n_rst(b_rst_n), .i_req(b_req), .i_lock(b_lock),
    .i_c_read_enable(b_re), .i_c_write_enable(b_we), .i_c_address(b_addr),
    .i_c_write_data(b_wdata), .i_read_data(rdata_in), .o_gnt(b_gnt),
    .o_rdata_valid(b_rdv), .o_c_read_data(b_crd), .o_read_enable(b_ren),
    .o_write_enable(b_wen), .o_address(b_address), .o_write_data(b_wd_out),
    .o_protocol_err(b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    a_rst_n = 1'b0; b_rst_n = 1'b0; rdata_in = 32'hA5A5_0001;
    a_req = 2'b00; a_lock = 2'b00; a_re = 2'b00; a_we = 2'b00;
    a_addr = 48'h0; a_wdata = 64'h0;
    b_req = 4'b0000; b_lock = 4'b0000; b_re = 4'b0000; b_we = 4'b0000;
    b_addr = 96'h0; b_wdata = 128'h0;
    tick(); tick();

    check_val("a_rst_gnt", 64'(a_gnt), 64'h0);
    check_val("a_rst_rdv", 64'(a_rdv), 64'h0);
    check_val("a_rst_strobes", 64'({a_ren, a_wen, a_err}), 64'h0);
    check_val("a_rst_addr", 64'(a_address), 64'h0);
    check_val("a_rst_wdata", 64'(a_wd_out), 64'h0);
    check_val("b_rst_gnt", 64'(b_gnt), 64'h0);
    check_val("b_rst_out", 64'({b_rdv, b_ren, b_wen, b_err, b_address, b_wd_out}), 64'h0);
    a_rst_n = 1'b1; b_rst_n = 1'b1;

    // ---- dut_a: round-robin handover
    a_req = 2'b11; tick();
    check_val("a_idle_grant", 64'(a_gnt), 64'h1);
    a_req = 2'b10; tick();
    check_val("a_zero_bubble", 64'(a_gnt), 64'h2);
    a_req = 2'b00; tick();
    check_val("a_to_idle", 64'(a_gnt), 64'h0);
    a_req = 2'b11; tick();
    check_val("a_rr_wrap", 64'(a_gnt), 64'h1);

    // ---- dut_a: single read by client0
    a_req = 2'b01; a_re = 2'b01; a_addr[23:0] = 24'h000040; tick();
    check_val("a_rd_ren", 64'(a_ren), 64'h1);
    check_val("a_rd_addr", 64'(a_address), 64'h40);
    check_val("a_rd_rdv_early", 64'(a_rdv), 64'h0);
    a_re = 2'b00; tick();
    check_val("a_rd_rdv", 64'(a_rdv), 64'h1);
    check_val("a_rd_ren_off", 64'(a_ren), 64'h0);
    check_val("a_rd_fanout", 64'(a_crd), 64'hA5A5_0001);
    tick();
    check_val("a_rd_rdv_once", 64'(a_rdv), 64'h0);

    // ---- dut_a: non-granted strobes ignored, then protocol error
    a_we = 2'b10; a_re = 2'b10; a_addr[47:24] = 24'hABCDEF; tick();
    check_val("a_nongnt_strobes", 64'({a_ren, a_wen}), 64'h0);
    check_val("a_nongnt_addr", 64'(a_address), 64'h40);
    a_we = 2'b01; a_re = 2'b01; a_addr[23:0] = 24'h123456; a_wdata[31:0] = 32'hDEAD_BEEF; tick();
    check_val("a_err_wen", 64'(a_wen), 64'h1);
    check_val("a_err_ren", 64'(a_ren), 64'h0);
    check_val("a_err_addr", 64'(a_address), 64'h123456);
    check_val("a_err_wdata", 64'(a_wd_out), 64'hDEAD_BEEF);
    check_val("a_err_flag", 64'(a_err), 64'h1);
    a_we = 2'b00; a_re = 2'b00; tick();
    check_val("a_err_sticky", 64'(a_err), 64'h1);
    check_val("a_err_no_rdv", 64'(a_rdv), 64'h0);

    // ---- dut_a: move rr to 1, client1 read burst, reset mid-burst
    a_req = 2'b00; tick();
    check_val("a_rel0", 64'(a_gnt), 64'h0);
    a_req = 2'b10; tick();
    check_val("a_gnt1", 64'(a_gnt), 64'h2);
    a_re = 2'b10; a_addr[47:24] = 24'h000100; tick();
    check_val("a_burst_ren", 64'(a_ren), 64'h1);
    tick();
    check_val("a_burst_rdv", 64'(a_rdv), 64'h2);
    a_rst_n = 1'b0; tick();
    check_val("a_mrst_gnt", 64'(a_gnt), 64'h0);
    check_val("a_mrst_out", 64'({a_rdv, a_ren, a_wen, a_err, a_address, a_wd_out}), 64'h0);
    a_rst_n = 1'b1; a_re = 2'b00; a_req = 2'b00; tick();
    check_val("a_flushed_rdv", 64'(a_rdv), 64'h0);
    a_req = 2'b11; tick();
    check_val("a_post_rst_rr", 64'(a_gnt), 64'h1);

    // ---- dut_b: client2 reads then releases, tags survive handover to client3
    b_req = 4'b0100; tick();
    check_val("b_gnt2", 64'(b_gnt), 64'h4);
    b_req = 4'b1100; b_re = 4'b0100; b_addr[71:48] = 24'h000010; tick();
    check_val("b_rd1_ren", 64'(b_ren), 64'h1);
    check_val("b_rd1_addr", 64'(b_address), 64'h10);
    b_addr[71:48] = 24'h000011; tick();
    check_val("b_rd2_addr", 64'(b_address), 64'h11);
    b_req = 4'b1000; b_re = 4'b0000; tick();
    check_val("b_handover", 64'(b_gnt), 64'h8);
    check_val("b_handover_ren", 64'(b_ren), 64'h0);
    check_val("b_rdv_e3", 64'(b_rdv), 64'h0);
    b_re = 4'b1000; b_addr[95:72] = 24'h000020; tick();
    check_val("b_rdv_e4", 64'(b_rdv), 64'h4);
    check_val("b_rd3_addr", 64'(b_address), 64'h20);
    b_re = 4'b0000; tick();
    check_val("b_rdv_e5", 64'(b_rdv), 64'h4);
    tick();
    check_val("b_rdv_e6", 64'(b_rdv), 64'h0);
    tick();
    check_val("b_rdv_e7", 64'(b_rdv), 64'h8);
    b_req = 4'b0000; tick();
    check_val("b_rdv_e8", 64'(b_rdv), 64'h0);
    check_val("b_idle", 64'(b_gnt), 64'h0);

    // ---- dut_b: preemption after hold expires, access on revoke edge kept
    b_req = 4'b0001; tick();
    check_val("b_pre_gnt0", 64'(b_gnt), 64'h1);
    b_req = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_val("b_pre_hold", 64'(b_gnt), 64'h1);
    end
    b_we = 4'b0001; b_addr[23:0] = 24'h000077; b_wdata[31:0] = 32'h0000_7777; tick();
    check_val("b_preempt", 64'(b_gnt), 64'h2);
    check_val("b_revoke_wen", 64'(b_wen), 64'h1);
    check_val("b_revoke_addr", 64'(b_address), 64'h77);
    check_val("b_revoke_wdata", 64'(b_wd_out), 64'h7777);
    b_we = 4'b0000; b_req = 4'b0010; tick();
    check_val("b_owner1", 64'(b_gnt), 64'h2);
    b_req = 4'b0000; tick();
    check_val("b_idle2", 64'(b_gnt), 64'h0);

    // ---- dut_b: locked owner is never preempted; unlock lets the waiter in
    b_req = 4'b0001; b_lock = 4'b0001; tick();
    check_val("b_lock_gnt", 64'(b_gnt), 64'h1);
    b_req = 4'b0011;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_val("b_lock_hold", 64'(b_gnt), 64'h1);
    end
    b_lock = 4'b0000; tick();
    check_val("b_unlock_preempt", 64'(b_gnt), 64'h2);
    check_val("b_no_err", 64'(b_err), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Parametrised N-client arbiter for the shared 1536-bit frame SRAM port. Generalises the two-client fill/alpha select into a registered round-robin arbiter with ownership handshakes, optional lock, hold-time preemption, and per-client routing of read-data valid across a fixed SRAM read latency. Sits between the pixel engines (fill, alpha blend, future texture/clear units) and the top-level SRAM pins.

## Interface
- NUM_CLIENTS, 2: number of requesting engines (2..8).
- ADDR_W, 24: SRAM address width.
- DATA_W, 1536: SRAM data width.
- RD_LATENCY, 1: cycles from SRAM-side read_enable to valid read_data (1..4).
- MAX_HOLD, 0: max cycles an unlocked owner keeps the port while others wait; 0 disables preemption.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- n_rst  in  1  synchronous, active-low reset.
- req  in  NUM_CLIENTS  client wants port ownership; held high while owning.
- lock  in  NUM_CLIENTS  owner forbids preemption while high.
- c_read_enable  in  NUM_CLIENTS  per-client read strobe.
- c_write_enable  in  NUM_CLIENTS  per-client write strobe.
- c_address  in  NUM_CLIENTS*ADDR_W  packed addresses, client i at [i*ADDR_W +: ADDR_W].
- c_write_data  in  NUM_CLIENTS*DATA_W  packed write data, same packing.
- gnt  out  NUM_CLIENTS  one-hot (or zero) ownership, registered.
- rdata_valid  out  NUM_CLIENTS  one-hot: shared read_data belongs to client i this cycle.
- read_data  in  DATA_W  SRAM read data (fanned out to all clients unchanged).
- read_enable, write_enable  out  1  SRAM strobes, registered.
- address  out  ADDR_W  SRAM address, registered.
- write_data  out  DATA_W  SRAM write data, registered.
- protocol_err  out  1  sticky: client drove read and write together while granted.

## Operation
- States: IDLE (gnt=0), OWNED (gnt one-hot). Round-robin pointer rr = index after last owner.
- IDLE: any req high -> grant first requester searching from rr upward with wrap; enter OWNED.
- OWNED, owner req low: gnt moves directly to next requester in RR order (zero-bubble handover) or IDLE if none; rr = owner+1 mod NUM_CLIENTS.
- Preemption (MAX_HOLD>0): hold counter clears on each new grant, increments each OWNED cycle; when count == MAX_HOLD, another req high and owner lock low -> gnt revoked and handed over as on release. Owner must drop and re-raise req; its req stays in the round-robin pool.
- Only the granted client's strobes/address/data are captured; strobes of non-granted clients ignored, no error.
- Granted client with both strobes high: write performed, read dropped, protocol_err set until reset.
- Read tag pipeline: RD_LATENCY-deep shift register of (valid, client index) pushed on each SRAM read; rdata_valid decoded from the tail. Tags survive handover, so outstanding reads of the previous owner still route correctly.

## Timing
- req at edge t (IDLE) -> gnt at t+1.
- Client access sampled at edge k with gnt high -> SRAM strobes/address/data at k+1 (one-cycle registered stage).
- Read sampled at k -> rdata_valid[i] and read_data valid at k+1+RD_LATENCY, exactly one cycle per read.
- Back-to-back accesses: one per cycle, full throughput.
- Release at k (req low) -> new owner's gnt at k+1; last access of old owner is the one sampled at k-1.
- Access sampled in the same cycle gnt is being revoked (preemption) is still performed.
- Reset: gnt, rdata_valid, read_enable, write_enable, address, write_data, protocol_err all 0; rr=0; hold counter 0; tag pipeline cleared (in-flight reads lost, no rdata_valid).

## Structure
- Package gpu_mem_pkg: default ADDR_W/DATA_W constants, arbiter state enum, client-index typedef width $clog2(NUM_CLIENTS).
- Sub-module rr_pick: combinational round-robin selector (req vector, rr pointer -> one-hot pick, any).

## Test plan
- NUM_CLIENTS=2, req=2'b01 at t -> gnt=01 at t+1; read addr 0x000040 at t+1 -> read_enable/address=0x000040 at t+2, rdata_valid=01 at t+2+RD_LATENCY.
- req=2'b11 from IDLE with rr=0 -> gnt=01; client0 drops req -> gnt=10 next cycle, no bubble; client1 drops -> IDLE, next 11 grants client0.
- NUM_CLIENTS=4, RD_LATENCY=3: client2 issues reads, releases; client3 granted -> client2's pending rdata_valid bits still arrive on cycles k+4, k+5.
- MAX_HOLD=4, client0 owns unlocked, client1 requests -> gnt passes to client1 after 4 held cycles; repeat with lock[0]=1 -> client0 keeps port indefinitely.
- Granted client drives read and write with addr 0x123456 -> write_enable=1, read_enable=0, protocol_err=1 and sticky; non-granted strobes produce no SRAM activity.
- n_rst low for one cycle mid-read-burst -> all outputs 0 next cycle, no rdata_valid for flushed reads, next grant starts from client0.
